// File: rtl/step_shaper_pkg.sv
// Shared types and sizing helpers for the step pulse shaper.
package step_shaper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } axis_state_e;

    // Timer must hold the largest of the three phase lengths.
    function automatic int timer_w(input int high_cyc, input int low_cyc, input int setup_cyc);
        int m;
        m = high_cyc;
        if (low_cyc > m)   m = low_cyc;
        if (setup_cyc > m) m = setup_cyc;
        return $clog2(m + 1);
    endfunction

    // FIFO pointer width for a power-of-two depth.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/step_pulse_shaper_axis.sv
// One axis: request edge detect, direction FIFO, pulse FSM with timer,
// and signed position counter.
module axis_shaper
    import step_shaper_pkg::*;
#(
    parameter int PULSE_HIGH_CYC = 100,
    parameter int PULSE_LOW_CYC  = 100,
    parameter int DIR_SETUP_CYC  = 50,
    parameter int FIFO_DEPTH     = 16,
    parameter int POS_W          = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             step_i,
    input  logic             dir_i,
    input  logic             pos_clr_i,
    input  logic             ovf_clr_i,
    output logic             step_o,
    output logic             dir_o,
    output logic             busy_o,
    output logic             ovf_o,
    output logic [POS_W-1:0] pos_o
);
    localparam int TW = timer_w(PULSE_HIGH_CYC, PULSE_LOW_CYC, DIR_SETUP_CYC);
    localparam int PW = ptr_w(FIFO_DEPTH);

    localparam logic [TW-1:0]    HIGH_LD   = TW'(PULSE_HIGH_CYC - 1);
    localparam logic [TW-1:0]    LOW_LD    = TW'(PULSE_LOW_CYC - 1);
    localparam logic [TW-1:0]    SETUP_LD  = TW'(DIR_SETUP_CYC - 1);
    localparam logic [TW-1:0]    TMR_ONE   = TW'(1);
    localparam logic [PW-1:0]    PTR_ONE   = PW'(1);
    localparam logic [PW:0]      CNT_ONE   = (PW+1)'(1);
    localparam logic [PW:0]      CNT_FULL  = (PW+1)'(FIFO_DEPTH);
    localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);

    logic                  step_prev_q;
    logic [FIFO_DEPTH-1:0] fifo_q;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]           cnt_q;
    logic                  ovf_q;
    axis_state_e           state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  dir_q, dir_d;
    logic [POS_W-1:0]      pos_q, pos_d;

    logic req, empty, full, pop, push_try, push, drop, head, hi_entry;

    assign req      = step_i & ~step_prev_q;
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_FULL);
    assign head     = fifo_q[rd_ptr_q];
    assign pop      = enable_i & ~empty & (state_q == ST_IDLE);
    assign push_try = enable_i & req;
    // A full FIFO still accepts a push when the same cycle pops.
    assign push     = push_try & (~full | pop);
    assign drop     = push_try & full & ~pop;

    // Edge detect on the raw step request.
    always_ff @(posedge clk_i) begin
        if (rst_i) step_prev_q <= 1'b0;
        else       step_prev_q <= step_i;
    end

    // Direction FIFO; enable low flushes it.
    always_ff @(posedge clk_i) begin
        if (rst_i || !enable_i) begin
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= dir_i;
                wr_ptr_q         <= wr_ptr_q + PTR_ONE;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Sticky overflow; a new drop wins over a coincident clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) ovf_q <= 1'b0;
        else       ovf_q <= (ovf_q & ~ovf_clr_i) | drop;
    end

    // FSM state, phase timer and registered direction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dir_q   <= dir_d;
        end
    end

    // Next state: direction only changes when leaving IDLE, so it is
    // stable through SETUP, HIGH and LOW.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    if (head == dir_q) begin
                        state_d = ST_HIGH;
                        timer_d = HIGH_LD;
                    end else begin
                        dir_d   = head;
                        state_d = ST_SETUP;
                        timer_d = SETUP_LD;
                    end
                end
            end
            ST_SETUP: begin
                if (timer_q == '0) begin
                    state_d = ST_HIGH;
                    timer_d = HIGH_LD;
                end else timer_d = timer_q - TMR_ONE;
            end
            ST_HIGH: begin
                if (timer_q == '0) begin
                    state_d = ST_LOW;
                    timer_d = LOW_LD;
                end else timer_d = timer_q - TMR_ONE;
            end
            ST_LOW: begin
                if (timer_q == '0) state_d = ST_IDLE;
                else               timer_d = timer_q - TMR_ONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        step_o   = (state_q == ST_HIGH);
        busy_o   = ~empty | (state_q != ST_IDLE);
        hi_entry = (state_d == ST_HIGH) & (state_q != ST_HIGH);
    end

    // Position next value: clear first, then apply the step on HIGH entry.
    always_comb begin
        pos_d = pos_clr_i ? '0 : pos_q;
        if (hi_entry) pos_d = dir_d ? (pos_d + POS_ONE) : (pos_d - POS_ONE);
    end

    // Position register, wraps modulo 2^POS_W.
    always_ff @(posedge clk_i) begin
        if (rst_i) pos_q <= '0;
        else       pos_q <= pos_d;
    end

    assign dir_o = dir_q;
    assign ovf_o = ovf_q;
    assign pos_o = pos_q;

endmodule

// File: rtl/step_pulse_shaper.sv
// Two independent step/dir shaping channels sharing enable and clear pulses.
module step_pulse_shaper
    import step_shaper_pkg::*;
#(
    parameter int PULSE_HIGH_CYC = 100,
    parameter int PULSE_LOW_CYC  = 100,
    parameter int DIR_SETUP_CYC  = 50,
    parameter int FIFO_DEPTH     = 16,
    parameter int POS_W          = 32
) (
    input  logic             PCLK,
    input  logic             PRESERN,
    input  logic             enable,
    input  logic             step1_in,
    input  logic             dir1_in,
    input  logic             step2_in,
    input  logic             dir2_in,
    input  logic             pos_clr,
    input  logic             ovf_clr,
    output logic             step1,
    output logic             dir1,
    output logic             step2,
    output logic             dir2,
    output logic [POS_W-1:0] pos1,
    output logic [POS_W-1:0] pos2,
    output logic             busy1,
    output logic             busy2,
    output logic             ovf1,
    output logic             ovf2
);
    axis_shaper #(
        .PULSE_HIGH_CYC(PULSE_HIGH_CYC), .PULSE_LOW_CYC(PULSE_LOW_CYC),
        .DIR_SETUP_CYC(DIR_SETUP_CYC), .FIFO_DEPTH(FIFO_DEPTH), .POS_W(POS_W)
    ) u_axis1 (
        .clk_i(PCLK), .rst_i(PRESERN), .enable_i(enable),
        .step_i(step1_in), .dir_i(dir1_in),
        .pos_clr_i(pos_clr), .ovf_clr_i(ovf_clr),
        .step_o(step1), .dir_o(dir1), .busy_o(busy1), .ovf_o(ovf1), .pos_o(pos1)
    );

    axis_shaper #(
        .PULSE_HIGH_CYC(PULSE_HIGH_CYC), .PULSE_LOW_CYC(PULSE_LOW_CYC),
        .DIR_SETUP_CYC(DIR_SETUP_CYC), .FIFO_DEPTH(FIFO_DEPTH), .POS_W(POS_W)
    ) u_axis2 (
        .clk_i(PCLK), .rst_i(PRESERN), .enable_i(enable),
        .step_i(step2_in), .dir_i(dir2_in),
        .pos_clr_i(pos_clr), .ovf_clr_i(ovf_clr),
        .step_o(step2), .dir_o(dir2), .busy_o(busy2), .ovf_o(ovf2), .pos_o(pos2)
    );

endmodule

// File: tb/tb_step_pulse_shaper.sv
// Directed bench for step_pulse_shaper with HIGH=4, LOW=3, SETUP=2, depth 16.
module tb_step_pulse_shaper;

    logic        PCLK = 1'b0;
    logic        PRESERN, enable, step1_in, dir1_in, step2_in, dir2_in, pos_clr, ovf_clr;
    logic        step1, dir1, step2, dir2, busy1, busy2, ovf1, ovf2;
    logic [31:0] pos1, pos2;

    int          checks = 0;
    int          errors = 0;
    int          idx = 0;
    int          rises2 = 0;
    logic        last_step2 = 1'b0;
    logic [31:0] s_step1, s_step2, s_dir1, s_busy1;

    step_pulse_shaper #(
        .PULSE_HIGH_CYC(4), .PULSE_LOW_CYC(3), .DIR_SETUP_CYC(2),
        .FIFO_DEPTH(16), .POS_W(32)
    ) dut (
        .PCLK(PCLK), .PRESERN(PRESERN), .enable(enable),
        .step1_in(step1_in), .dir1_in(dir1_in), .step2_in(step2_in), .dir2_in(dir2_in),
        .pos_clr(pos_clr), .ovf_clr(ovf_clr),
        .step1(step1), .dir1(dir1), .step2(step2), .dir2(dir2),
        .pos1(pos1), .pos2(pos2), .busy1(busy1), .busy2(busy2), .ovf1(ovf1), .ovf2(ovf2)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One cycle: drive step requests, sample mid-cycle, advance past the edge.
    task automatic cycle_step(input logic s1, input logic s2);
        step1_in = s1;
        step2_in = s2;
        @(negedge PCLK);
        if (idx < 32) begin
            s_step1[idx] = step1;
            s_step2[idx] = step2;
            s_dir1[idx]  = dir1;
            s_busy1[idx] = busy1;
        end
        if (step2 && !last_step2) rises2++;
        last_step2 = step2;
        idx++;
        @(posedge PCLK);
        #1;
    endtask

    task automatic clr_samples();
        idx = 0; rises2 = 0; last_step2 = 1'b0;
        s_step1 = '0; s_step2 = '0; s_dir1 = '0; s_busy1 = '0;
    endtask

    task automatic do_reset();
        PRESERN = 1'b1; pos_clr = 1'b0; ovf_clr = 1'b0; enable = 1'b1;
        cycle_step(1'b0, 1'b0);
        cycle_step(1'b0, 1'b0);
        PRESERN = 1'b0;
        clr_samples();
    endtask

    initial begin
        PRESERN = 1'b1; enable = 1'b1; step1_in = 1'b0; step2_in = 1'b0;
        dir1_in = 1'b0; dir2_in = 1'b0; pos_clr = 1'b0; ovf_clr = 1'b0;
        @(posedge PCLK); #1;

        // Reset state
        do_reset();
        chk("rst_bits", {24'd0, step1, step2, dir1, dir2, busy1, busy2, ovf1, ovf2}, 32'd0);
        chk("rst_pos1", pos1, 32'd0);
        chk("rst_pos2", pos2, 32'd0);

        // Single step, same direction: high cycles 2..5, busy 1..8, pos -1
        dir1_in = 1'b0;
        for (int i = 0; i < 13; i++) cycle_step(i == 0, 1'b0);
        chk("s1_step", {19'd0, s_step1[12:0]}, 32'h0000_003C);
        chk("s1_busy", {19'd0, s_busy1[12:0]}, 32'h0000_01FE);
        chk("s1_dir",  {19'd0, s_dir1[12:0]},  32'd0);
        chk("s1_pos",  pos1, 32'hFFFF_FFFF);

        // Direction change: dir from 2, high 4..7, busy 1..10, pos +1
        do_reset();
        dir1_in = 1'b1;
        for (int i = 0; i < 12; i++) cycle_step(i == 0, 1'b0);
        chk("s2_dir",   {20'd0, s_dir1[11:0]},  32'h0000_0FFC);
        chk("s2_step",  {20'd0, s_step1[11:0]}, 32'h0000_00F0);
        chk("s2_busy",  {20'd0, s_busy1[11:0]}, 32'h0000_07FE);
        chk("s2_pos",   pos1, 32'd1);
        chk("s2_step2", {20'd0, s_step2[11:0]}, 32'd0);
        chk("s2_pos2",  pos2, 32'd0);

        // pos_clr in the cycle HIGH is entered: clear then +1
        clr_samples();
        cycle_step(1'b1, 1'b0);
        pos_clr = 1'b1;
        cycle_step(1'b0, 1'b0);
        pos_clr = 1'b0;
        cycle_step(1'b0, 1'b0);
        chk("clr_step", {31'd0, s_step1[2]}, 32'd1);
        chk("clr_pos",  pos1, 32'd1);

        // Overflow on axis 2: 24 requests every 2 cycles; pops at 1,11,19,...
        // requests 21 and 23 land on a full FIFO, so 22 are accepted.
        do_reset();
        dir2_in = 1'b1;
        for (int i = 0; i < 48; i++) cycle_step(1'b0, (i % 2) == 0);
        chk("ovf_set", {31'd0, ovf2}, 32'd1);
        begin
            int n = 0;
            while (busy2 && n < 400) begin
                cycle_step(1'b0, 1'b0);
                n++;
            end
        end
        chk("ovf_drain", {31'd0, busy2}, 32'd0);
        chk("ovf_pulses", rises2, 32'd22);
        chk("ovf_pos2", pos2, 32'd22);
        chk("ovf_hold", {31'd0, ovf2}, 32'd1);
        chk("ovf_ax1", {31'd0, ovf1}, 32'd0);
        ovf_clr = 1'b1;
        cycle_step(1'b0, 1'b0);
        ovf_clr = 1'b0;
        chk("ovf_clr", {31'd0, ovf2}, 32'd0);

        // Enable dropped during second HIGH (cycles 12..15): it completes, nothing after
        do_reset();
        dir1_in = 1'b1;
        for (int i = 0; i < 24; i++) begin
            enable = (i < 13);
            cycle_step((i < 10) && ((i % 2) == 0), 1'b0);
        end
        chk("en_step", {8'd0, s_step1[23:0]}, 32'h0000_F0F0);
        chk("en_busy", {27'd0, s_busy1[23:19]}, 32'd0);
        chk("en_pos",  pos1, 32'd2);
        enable = 1'b1;

        // Reset asserted in cycle 5 while HIGH; cycle 6 is fully cleared
        do_reset();
        dir1_in = 1'b1;
        for (int i = 0; i < 13; i++) begin
            PRESERN = (i == 5);
            cycle_step((i == 0) || (i == 2), 1'b0);
        end
        chk("rm_step", {29'd0, s_step1[6:4]}, 32'h3);
        chk("rm_dir",  {27'd0, s_dir1[6:2]},  32'h0F);
        chk("rm_busy", {25'd0, s_busy1[12:6]}, 32'd0);
        chk("rm_idle", {25'd0, s_step1[12:6]}, 32'd0);
        chk("rm_pos",  pos1, 32'd0);

        // Request after the mid-pulse reset behaves like a fresh single step
        clr_samples();
        dir1_in = 1'b0;
        for (int i = 0; i < 13; i++) cycle_step(i == 0, 1'b0);
        chk("rm2_step", {19'd0, s_step1[12:0]}, 32'h0000_003C);
        chk("rm2_pos",  pos1, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
